// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream consumer (rc4_xor_cipher).
package rc4_pkg;
    localparam int BYTE_W     = 8;
    localparam int DROP_CNT_W = 16;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        DROP_ST_DROP = 1'b0,
        DROP_ST_RUN  = 1'b1
    } drop_state_e;
endpackage

// File: rtl/rc4_ks_fifo.sv
// Keystream byte FIFO: push/pop/level, with same-cycle push+pop allowed when full.
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  byte_t                    wr_data,
    output byte_t                    rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    byte_t            mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // At full with a pop, the write lands on the slot being read this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign full    = (level_q == (PTR_W+1)'(DEPTH));
    assign empty   = (level_q == '0);
endmodule

// File: rtl/rc4_xor_cipher.sv
// XORs buffered RC4 keystream bytes with a plaintext stream into a registered ciphertext stream.
// Optional RC4-drop[N] front end enabled by defining RC4_XOR_DROP_EN.
module rc4_xor_cipher
    import rc4_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_N     = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ks_valid,
    input  logic [BYTE_W-1:0]             ks_data,
    input  logic                          pt_valid,
    output logic                          pt_ready,
    input  logic [BYTE_W-1:0]             pt_data,
    output logic                          ct_valid,
    input  logic                          ct_ready,
    output logic [BYTE_W-1:0]             ct_data,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   ks_level
);
    // Handshakes: a byte moves on any edge where valid && ready; valid never waits on ready.
    logic  dropping;
    logic  fifo_push, fifo_pop, fifo_full, fifo_empty;
    byte_t fifo_head;

    logic  ct_valid_q, ct_valid_d;
    byte_t ct_data_q, ct_data_d;
    logic  overflow_q, overflow_d;

`ifdef RC4_XOR_DROP_EN
    localparam logic [DROP_CNT_W-1:0] DROP_LAST = DROP_CNT_W'(DROP_N - 1);

    drop_state_e              drop_state_q, drop_state_d;
    logic [DROP_CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_state_d = drop_state_q;
        drop_cnt_d   = drop_cnt_q;
        if (drop_state_q == DROP_ST_DROP) begin
            if (DROP_N == 0) begin
                drop_state_d = DROP_ST_RUN;
            end else if (ks_valid) begin
                // The pulse that completes the count is itself discarded.
                if (drop_cnt_q == DROP_LAST) begin
                    drop_state_d = DROP_ST_RUN;
                end else begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_state_q <= DROP_ST_DROP;
            drop_cnt_q   <= '0;
        end else begin
            drop_state_q <= drop_state_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign dropping = (drop_state_q == DROP_ST_DROP);
`else
    localparam int unused_drop_n = DROP_N;
    assign dropping = 1'b0;
`endif

    assign pt_ready  = !fifo_empty && (!ct_valid_q || ct_ready) && !dropping;
    assign fifo_pop  = pt_valid && pt_ready;
    assign fifo_push = ks_valid && !dropping && (!fifo_full || fifo_pop);

    always_comb begin
        ct_valid_d = ct_valid_q;
        ct_data_d  = ct_data_q;
        overflow_d = overflow_q || (ks_valid && !dropping && fifo_full && !fifo_pop);
        if (fifo_pop) begin
            ct_valid_d = 1'b1;
            ct_data_d  = pt_data ^ fifo_head;
        end else if (ct_ready) begin
            ct_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ct_valid_q <= 1'b0;
            ct_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            ct_valid_q <= ct_valid_d;
            ct_data_q  <= ct_data_d;
            overflow_q <= overflow_d;
        end
    end

    rc4_ks_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (ks_data),
        .rd_data (fifo_head),
        .level   (ks_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ct_valid = ct_valid_q;
    assign ct_data  = ct_data_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_rc4_xor_cipher.sv
// Self-checking bench for rc4_xor_cipher: known-answer, backpressure, overflow, full push+pop,
// async reset and (with RC4_XOR_DROP_EN) the drop front end.
module tb_rc4_xor_cipher;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ks_valid = 1'b0;
    logic [7:0] ks_data = '0;
    logic       pt_valid = 1'b0;
    logic       pt_ready;
    logic [7:0] pt_data = '0;
    logic       ct_valid;
    logic       ct_ready = 1'b1;
    logic [7:0] ct_data;
    logic       overflow;
    logic [4:0] ks_level;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    logic [7:0] kat_ks [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] kat_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] kat_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    rc4_xor_cipher #(.FIFO_DEPTH(16), .DROP_N(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ks_valid (ks_valid),
        .ks_data  (ks_data),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .overflow (overflow),
        .ks_level (ks_level)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks: all entered and left at posedge+1.
    task automatic ks_pulse(input logic [7:0] b);
        ks_valid = 1'b1;
        ks_data  = b;
        @(posedge clk); #1;
        ks_valid = 1'b0;
    endtask

    task automatic release_rst();
        rst = 1'b0;
        exp_q.delete();
`ifdef RC4_XOR_DROP_EN
        for (int i = 0; i < 4; i++) ks_pulse(8'h00);
`endif
    endtask

    task automatic do_reset();
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        rst      = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        release_rst();
    endtask

    task automatic send_pt(input logic [7:0] d, input logic [7:0] exp_ct);
        int  n = 0;
        bit  done = 1'b0;
        bit  ok = 1'b0;
        pt_valid = 1'b1;
        pt_data  = d;
        while (!done) begin
            @(negedge clk);
            if (pt_ready) begin
                exp_q.push_back(exp_ct);
                ok   = 1'b1;
                done = 1'b1;
            end else if (++n > 300) begin
                check("pt_accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        pt_valid = 1'b0;
        if (ok) begin
            @(negedge clk);
            check("ct_latency", 32'(ct_valid), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // Scoreboard / monitor
    bit         stall_prev = 1'b0;
    logic [7:0] data_prev  = '0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("ct_hold_valid", 32'(ct_valid), 32'd1);
                check("ct_hold_data", 32'(ct_data), 32'(data_prev));
            end
            if (ct_valid && !ct_ready) begin
                check("pt_ready_stall", 32'(pt_ready), 32'd0);
            end
            if (ct_valid && ct_ready) begin
                if (exp_q.size() == 0) check("ct_unexpected", 32'(ct_data), 32'hFFFF_FFFF);
                else check("ct_data", 32'(ct_data), 32'(exp_q.pop_front()));
            end
            stall_prev = ct_valid && !ct_ready;
            data_prev  = ct_data;
        end
    end

    initial begin
        // Reset values
        #1;
        check("rst_pt_ready", 32'(pt_ready), 32'd0);
        check("rst_ct_valid", 32'(ct_valid), 32'd0);
        check("rst_ct_data", 32'(ct_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_ks_level", 32'(ks_level), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;

`ifdef RC4_XOR_DROP_EN
        // Drop front end: four pulses discarded, pt_ready held low meanwhile
        rst = 1'b0;
        pt_valid = 1'b1;
        pt_data  = 8'h50;
        for (int i = 0; i < 4; i++) begin
            ks_valid = 1'b1;
            ks_data  = 8'h11 * 8'(i + 1);
            @(negedge clk);
            check("drop_pt_ready", 32'(pt_ready), 32'd0);
            @(posedge clk); #1;
        end
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        @(negedge clk);
        check("drop_level", 32'(ks_level), 32'd0);
        @(posedge clk); #1;
        ks_pulse(8'hEB);
        ks_pulse(8'h9F);
        send_pt(8'h50, 8'hBB);
        send_pt(8'h6C, 8'hF3);
        drain();
`else
        release_rst();
`endif

        // Known-answer vector, keystream every other cycle
        do_reset();
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    ks_pulse(kat_ks[i]);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int i = 0; i < 9; i++) send_pt(kat_pt[i], kat_ct[i]);
            end
        join
        drain();
        check("kat_overflow", 32'(overflow), 32'd0);

        // Backpressure mid-stream
        do_reset();
        fork
            begin
                for (int i = 0; i < 9; i++) begin
                    ks_pulse(kat_ks[i]);
                    @(posedge clk); #1;
                end
            end
            begin
                for (int i = 0; i < 9; i++) send_pt(kat_pt[i], kat_ct[i]);
            end
            begin
                repeat (8) @(posedge clk);
                #1 ct_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 ct_ready = 1'b1;
            end
        join
        drain();
        check("bp_level", 32'(ks_level), 32'd0);

        // Overflow: 17 back-to-back pulses into a 16-deep FIFO
        do_reset();
        for (int i = 0; i <= 16; i++) ks_pulse(8'(i));
        @(negedge clk);
        check("ovf_level", 32'(ks_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send_pt(8'h00, 8'(i));
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_empty", 32'(ks_level), 32'd0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 16; i++) ks_pulse(8'h20 + 8'(i));
        ks_valid = 1'b1;
        ks_data  = 8'h30;
        pt_valid = 1'b1;
        pt_data  = 8'h00;
        @(negedge clk);
        check("full_level_pre", 32'(ks_level), 32'd16);
        check("full_pt_ready", 32'(pt_ready), 32'd1);
        if (pt_ready) exp_q.push_back(8'h20);
        @(posedge clk); #1;
        ks_valid = 1'b0;
        pt_valid = 1'b0;
        @(negedge clk);
        check("full_level_post", 32'(ks_level), 32'd16);
        check("full_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        for (int i = 1; i <= 16; i++) send_pt(8'h00, 8'h20 + 8'(i));
        drain();

        // Asynchronous reset with a held ct byte and level 5
        do_reset();
        ct_ready = 1'b0;
        for (int i = 1; i <= 6; i++) ks_pulse(8'(i));
        send_pt(8'h00, 8'h01);
        @(negedge clk);
        check("mid_ct_valid", 32'(ct_valid), 32'd1);
        check("mid_level", 32'(ks_level), 32'd5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_ct_valid", 32'(ct_valid), 32'd0);
        check("async_pt_ready", 32'(pt_ready), 32'd0);
        check("async_ks_level", 32'(ks_level), 32'd0);
        check("async_ct_data", 32'(ct_data), 32'd0);
        @(posedge clk); #1;
        ct_ready = 1'b1;
        release_rst();
        ks_pulse(8'h5A);
        send_pt(8'h33, 8'h69);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rc4_xor_cipher.md
Name: rc4_xor_cipher

Overview:
Downstream consumer of the RC4 keystream generator. Buffers keystream bytes, which arrive as one-cycle pulses on the generator's output_ready/K and cannot be back-pressured, in a small FIFO. Each buffered byte is XORed with one plaintext byte accepted over a valid/ready handshake, and the result is presented as ciphertext on a registered valid/ready output. Encryption and decryption are the same operation.

Parameters:
FIFO_DEPTH, 16, keystream FIFO entries; power of two, minimum 2.
DROP_N, 256, number of initial keystream bytes discarded; used only when RC4_XOR_DROP_EN is defined; range 0..65535.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
ks_valid  input  1  keystream byte present this cycle; tie to generator output_ready
ks_data  input  8  keystream byte; tie to generator K
pt_valid  input  1  plaintext byte offered
pt_ready  output  1  plaintext byte accepted when pt_valid && pt_ready
pt_data  input  8  plaintext byte
ct_valid  output  1  ciphertext byte held
ct_ready  input  1  downstream accepts ciphertext
ct_data  output  8  ciphertext byte
overflow  output  1  sticky: a keystream byte was lost because the FIFO was full
ks_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high) values: pt_ready=0, ct_valid=0, ct_data=0, overflow=0, ks_level=0. FIFO pointers and drop counter are cleared; any buffered data is lost. Reset asserted mid-stream takes effect immediately, with no partial-output glitch beyond the async clear.
- ks_valid is sampled every cycle. Each cycle it is high counts as exactly one byte, including back-to-back highs.
- Push: a byte is written when ks_valid, not dropping, and (level<FIFO_DEPTH or a pop occurs the same cycle).
- Full: when full with no pop in the same cycle, the ks byte is discarded and overflow is set to 1. overflow stays 1 until reset.
- pt_ready = (level!=0) && (!ct_valid || ct_ready). This is combinational from registered state plus ct_ready; there is no path from pt_valid.
- Accept (pt_valid && pt_ready): pop the FIFO head; on the next edge ct_data <= pt_data ^ head and ct_valid <= 1. Latency from accept to ct_valid is 1 cycle.
- ct_valid clears on ct_ready unless a new accept occurs in the same cycle, in which case it stays 1 with new data. Throughput is 1 byte/cycle while keystream is available.
- ct_data is held stable while ct_valid && !ct_ready.
- Empty FIFO: pt_ready=0. A keystream byte pushed into an empty FIFO appears in level on the next cycle, and pt_ready may assert that cycle. No bypass.
- Simultaneous push and pop: level is unchanged and both operations succeed, including at full and at level 1.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Level is one bit wider, so full and empty are distinguishable.
- Keystream bytes are consumed strictly in arrival order; plaintext byte n always pairs with kept keystream byte n.

Optional Feature:
RC4_XOR_DROP_EN (RC4-drop[N]):
- Defined: two-state control. DROP (reset state) counts ks_valid pulses in a 16-bit counter without pushing. After DROP_N pulses it moves to RUN, and the pulse that completes the count is also discarded. DROP_N=0 enters RUN on the first cycle after reset. In RUN the block pushes normally. pt_ready=0 throughout DROP.
- Undefined: no counter and no states; the block behaves permanently as RUN. DROP_N is ignored.

Decomposition:
- Shared package rc4_pkg: BYTE_W=8, byte typedef, and the drop-counter width of 16.
- Natural sub-module rc4_ks_fifo: synchronous FIFO with push/pop/level/full/empty and same-cycle push+pop at full permitted. Parent holds the XOR output register, handshake logic, overflow flag and drop control.

Test Plan:
- Known-answer vector:
  - Stimulus: ks pulses EB 9F 77 81 B7 34 CA 72 A7 (RC4 key "Key") every other cycle; pt "Plaintext" 50 6C 61 69 6E 74 65 78 74; ct_ready=1.
  - Response: ct BB F3 16 E8 D9 40 AF 0A D3, each 1 cycle after its accept; overflow=0.
- Backpressure:
  - Stimulus: same vector with ct_ready low for 5 cycles mid-stream.
  - Response: ct_data held stable and pt_ready=0 while stalled; identical output sequence; no byte lost or duplicated.
- Overflow:
  - Stimulus: FIFO_DEPTH=16, pt_valid=0, 17 consecutive ks pulses 00..10.
  - Response: level=16, overflow=1 after byte 0x10; subsequent pt stream with pt=00 yields ct 00..0F.
- Full with simultaneous push+pop:
  - Stimulus: fill 16 bytes, then ks pulse and pt accept in the same cycle.
  - Response: level stays 16, overflow=0, new byte retained in order.
- Reset mid-operation:
  - Stimulus: rst pulse while ct_valid=1 and level=5.
  - Response: ct_valid, pt_ready and ks_level go to 0 asynchronously; after release the next ks byte pairs with the next pt byte.
- RC4_XOR_DROP_EN with DROP_N=4:
  - Stimulus: ks 11 22 33 44 EB 9F, pt 50 6C.
  - Response: pt_ready=0 until after the 4th pulse; ct BB F3.
